// File: rtl/note_record_sequencer_pkg.sv
// Shared piano datapath definitions: note codes, tick rate, sequencer state
// encoding and the {note, dur} layout of a recorded buffer entry.
package piano_pkg;

    localparam int NOTE_BITS     = 5;
    localparam int DUR_BITS      = 12;
    localparam int TICK_DIV_5MHZ = 50000;

    localparam logic [NOTE_BITS-1:0] REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_LOAD = 2'd2,
        ST_PLAY = 2'd3
    } seq_state_e;

    // Buffer entry: note in the upper bits, duration (ticks) in the lower bits.
    typedef struct packed {
        logic [NOTE_BITS-1:0] note;
        logic [DUR_BITS-1:0]  dur;
    } note_entry_t;

endpackage

// File: rtl/note_record_sequencer_if.sv
// Control/status bundle between the key decoder side and the note sequencer.
interface note_record_sequencer_if #(
    parameter int NOTE_W = 5,
    parameter int ADDR_W = 6
);
    logic [NOTE_W-1:0] key_note;
    logic              rec_start;
    logic              play_start;
    logic [NOTE_W-1:0] note_out;
    logic [1:0]        state;
    logic              busy;
    logic              full;
    logic [ADDR_W:0]   count;

    modport master (
        output key_note, rec_start, play_start,
        input  note_out, state, busy, full, count
    );

    modport slave (
        input  key_note, rec_start, play_start,
        output note_out, state, busy, full, count
    );
endinterface

// File: rtl/note_record_sequencer_note_ram.sv
// Note buffer: one write port, one registered read port, contents never reset.
module note_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WIDTH  = 17
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/note_record_sequencer.sv
// Owns the tone generator note: passes the live key through, records it as
// (note, duration) segments, and replays the buffer with tick-accurate timing.
module note_record_sequencer
    import piano_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int NOTE_W   = NOTE_BITS,
    parameter int DUR_W    = DUR_BITS,
    parameter int TICK_DIV = TICK_DIV_5MHZ
) (
    input  logic                    CLK,
    input  logic                    nCLR,
    note_record_sequencer_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = NOTE_W + DUR_W;

    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [DUR_W-1:0] DUR_PRE   = DUR_MAX - 1'b1;
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_C    = (ADDR_W + 1)'(DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [NOTE_W-1:0] note_out_q, note_out_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic [DUR_W-1:0]  dcnt_q, dcnt_d;

    logic              tick;
    logic              we;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic              last_entry;

    assign tick       = (presc_q == TICK_LAST);
    assign rd_note    = rdata[EW-1 -: NOTE_W];
    assign rd_dur     = rdata[DUR_W-1:0];
    assign last_entry = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

    // Read address is the next pointer so the entry is on rdata during LOAD.
    note_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (EW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (we),
        .waddr_i (count_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d    = state_q;
        note_out_d = note_out_q;
        full_d     = full_q;
        count_d    = count_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        dur_d      = dur_q;
        rd_ptr_d   = rd_ptr_q;
        cur_note_d = cur_note_q;
        dcnt_d     = dcnt_q;
        we         = 1'b0;
        wdata      = {cur_note_q, dur_q};

        unique case (state_q)
            ST_IDLE: begin
                note_out_d = bus.key_note;
                if (bus.rec_start) begin
                    state_d    = ST_REC;
                    count_d    = '0;
                    full_d     = 1'b0;
                    dur_d      = '0;
                    cur_note_d = bus.key_note;
                    presc_d    = '0;
                end else if (bus.play_start && (count_q != '0)) begin
                    state_d    = ST_LOAD;
                    rd_ptr_d   = '0;
                    note_out_d = NOTE_W'(REST);
                end
            end

            ST_REC: begin
                note_out_d = bus.key_note;
                if (bus.rec_start) begin
                    state_d = ST_IDLE;
                    we      = (dur_q != '0) && (count_q < DEPTH_C);
                end else if (bus.key_note != cur_note_q) begin
                    we         = 1'b1;
                    cur_note_d = bus.key_note;
                    dur_d      = '0;
                end else if (tick) begin
                    // A tick that would complete a maximal segment closes it
                    // and the same note carries on in a fresh entry.
                    if (dur_q == DUR_PRE) begin
                        we    = 1'b1;
                        wdata = {cur_note_q, DUR_MAX};
                        dur_d = '0;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                if (we) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_C) begin
                        full_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOAD: begin
                presc_d    = '0;
                state_d    = ST_PLAY;
                note_out_d = rd_note;
                dcnt_d     = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            end

            ST_PLAY: begin
                if (bus.play_start) begin
                    state_d    = ST_IDLE;
                    note_out_d = bus.key_note;
                end else if (tick) begin
                    if (dcnt_q <= DUR_W'(1)) begin
                        if (last_entry) begin
                            state_d    = ST_IDLE;
                            note_out_d = bus.key_note;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            state_d  = ST_LOAD;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q    <= ST_IDLE;
            note_out_q <= '0;
            full_q     <= 1'b0;
            count_q    <= '0;
            presc_q    <= '0;
            dur_q      <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            note_out_q <= note_out_d;
            full_q     <= full_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Segment note and playback down-counter are always written before use.
    always_ff @(posedge CLK) begin
        cur_note_q <= cur_note_d;
        dcnt_q     <= dcnt_d;
    end

    assign bus.note_out = note_out_q;
    assign bus.state    = state_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.full     = full_q;
    assign bus.count    = count_q;

endmodule
